// File: rtl/inst_fetch.sv
// IF stage plus IF/ID register: PC, instruction SRAM read port, stall/redirect handling.
// Define FETCH_BUFFER_EN to replace the single hold register with a 2-entry prefetch FIFO.
module inst_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = 'h0800
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a read is outstanding in every cycle with mem_req=1 and completes in
  // the cycle mem_ack=1, which is the only cycle mem_rdata is sampled; an ack seen
  // while mem_req=0 or while redirect_valid=1 is ignored.
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [INST_W-1:0] r_inst, w_inst_nxt;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out_nxt;
  logic              r_valid, w_valid_nxt;
  logic              w_mem_req;
  logic              w_ack;

  assign mem_addr   = r_pc;
  assign mem_req    = w_mem_req;
  assign w_ack      = mem_ack & w_mem_req;
  assign inst_out   = r_inst;
  assign pc_out     = r_pc_out;
  assign inst_valid = r_valid;

`ifdef FETCH_BUFFER_EN
  logic [INST_W-1:0] r_q0_inst, r_q1_inst, w_q0_inst_nxt, w_q1_inst_nxt;
  logic [ADDR_W-1:0] r_q0_pc, r_q1_pc, w_q0_pc_nxt, w_q1_pc_nxt;
  logic [1:0]        r_count, w_count_nxt, w_count_left;
  logic              w_pop, w_push;

  // Request gated by reset so the port is quiet while rst is low.
  assign w_mem_req   = rst & (r_count != 2'd2);
  assign o_dbg_state = r_count;

  always_comb begin
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_pc_out_nxt  = r_pc_out;
    w_valid_nxt   = r_valid;
    w_q0_inst_nxt = r_q0_inst;
    w_q1_inst_nxt = r_q1_inst;
    w_q0_pc_nxt   = r_q0_pc;
    w_q1_pc_nxt   = r_q1_pc;
    w_count_nxt   = r_count;
    w_count_left  = r_count;
    w_pop         = 1'b0;
    w_push        = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_inst_nxt  = NOP_INST;
      w_valid_nxt = 1'b0;
      w_count_nxt = 2'd0;
    end else begin
      w_pop  = ~stall & (r_count != 2'd0);
      w_push = w_ack & (stall | (r_count != 2'd0));
      if (!stall) begin
        if (r_count != 2'd0) begin
          w_inst_nxt   = r_q0_inst;
          w_pc_out_nxt = r_q0_pc;
          w_valid_nxt  = 1'b1;
        end else if (w_ack) begin
          w_inst_nxt   = mem_rdata;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
        end else begin
          w_inst_nxt  = NOP_INST;
          w_valid_nxt = 1'b0;
        end
      end
      // Shift the head out first, then append behind whatever remains.
      if (w_pop) begin
        w_q0_inst_nxt = r_q1_inst;
        w_q0_pc_nxt   = r_q1_pc;
        w_count_left  = r_count - 2'd1;
      end
      if (w_push) begin
        if (w_count_left == 2'd0) begin
          w_q0_inst_nxt = mem_rdata;
          w_q0_pc_nxt   = r_pc;
        end else begin
          w_q1_inst_nxt = mem_rdata;
          w_q1_pc_nxt   = r_pc;
        end
      end
      w_count_nxt = w_count_left + {1'b0, w_push};
      if (w_ack) w_pc_nxt = r_pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_q0_inst <= NOP_INST;
      r_q1_inst <= NOP_INST;
      r_q0_pc   <= '0;
      r_q1_pc   <= '0;
      r_count   <= 2'd0;
    end else begin
      r_q0_inst <= w_q0_inst_nxt;
      r_q1_inst <= w_q1_inst_nxt;
      r_q0_pc   <= w_q0_pc_nxt;
      r_q1_pc   <= w_q1_pc_nxt;
      r_count   <= w_count_nxt;
    end
  end
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [INST_W-1:0] r_hold_inst, w_hold_inst_nxt;
  logic [ADDR_W-1:0] r_hold_pc, w_hold_pc_nxt;

  // Request gated by reset so the port is quiet while rst is low.
  assign w_mem_req   = rst & (r_state == S_FETCH);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inst_nxt      = r_inst;
    w_pc_out_nxt    = r_pc_out;
    w_valid_nxt     = r_valid;
    w_hold_inst_nxt = r_hold_inst;
    w_hold_pc_nxt   = r_hold_pc;
    if (redirect_valid) begin
      w_state_nxt     = S_FETCH;
      w_pc_nxt        = redirect_pc;
      w_inst_nxt      = NOP_INST;
      w_valid_nxt     = 1'b0;
      w_hold_inst_nxt = NOP_INST;
      w_hold_pc_nxt   = '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!stall) begin
            if (w_ack) begin
              w_inst_nxt   = mem_rdata;
              w_pc_out_nxt = r_pc;
              w_valid_nxt  = 1'b1;
              w_pc_nxt     = r_pc + ADDR_W'(1);
            end else begin
              w_inst_nxt  = NOP_INST;
              w_valid_nxt = 1'b0;
            end
          end else if (w_ack) begin
            // IF/ID is frozen, so park the returned word until the stall lifts.
            w_hold_inst_nxt = mem_rdata;
            w_hold_pc_nxt   = r_pc;
            w_pc_nxt        = r_pc + ADDR_W'(1);
            w_state_nxt     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_inst_nxt   = r_hold_inst;
            w_pc_out_nxt = r_hold_pc;
            w_valid_nxt  = 1'b1;
            w_state_nxt  = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_hold_inst <= NOP_INST;
      r_hold_pc   <= '0;
    end else begin
      r_hold_inst <= w_hold_inst_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
    end
  end
`endif

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_inst   <= NOP_INST;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_inst   <= w_inst_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: SRAM responder, architectural scoreboard of fetched words,
// directed reset/stream/wait/stall/redirect/wrap cases and a random tail.
module tb_inst_fetch;
  localparam logic [15:0] NOP = 16'h0800;
`ifdef FETCH_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic [1:0]  o_dbg_state;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_pc = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_inst = NOP;
  logic [15:0] m_pcout = '0;

  inst_fetch dut (
    .clk_50MHz      (clk_50MHz),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid),
    .o_dbg_state    (o_dbg_state)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, update the model, check after the edge.
  task automatic step(input logic s, input logic r, input logic [15:0] rpc, input logic a);
    logic [31:0] e;
    check_eq("mem_req", mem_req, exp_q.size() < DEPTH);
    if (mem_req) check_eq("mem_addr", mem_addr, m_pc);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = rpc;
    mem_ack        = a & mem_req;
    mem_rdata      = mem_ack ? (mem_addr ^ 16'hA000) : 16'($urandom);
    if (r) begin
      exp_q.delete();
      m_pc    = rpc;
      m_valid = 1'b0;
      m_inst  = NOP;
    end else begin
      if (mem_ack) begin
        exp_q.push_back({m_pc, m_pc ^ 16'hA000});
        m_pc = m_pc + 16'd1;
      end
      if (!s) begin
        if (exp_q.size() != 0) begin
          e       = exp_q.pop_front();
          m_valid = 1'b1;
          m_pcout = e[31:16];
          m_inst  = e[15:0];
        end else begin
          m_valid = 1'b0;
          m_inst  = NOP;
        end
      end
    end
    @(posedge clk_50MHz);
    #1;
    check_eq("inst_valid", inst_valid, m_valid);
    check_eq("inst_out", inst_out, m_inst);
    if (m_valid) check_eq("pc_out", pc_out, m_pcout);
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    #2;
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst_out", inst_out, NOP);
    check_eq("rst_pc_out", pc_out, 16'h0000);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    mem_ack        = 1'b0;
    exp_q.delete();
    m_pc    = 16'h0000;
    m_valid = 1'b0;
    m_inst  = NOP;
    m_pcout = 16'h0000;
    repeat (2) @(posedge clk_50MHz);
    #5;
    rst = 1'b1;
    #1;
    check_eq("rel_mem_req", mem_req, 1'b1);
    check_eq("rel_mem_addr", mem_addr, 16'h0000);
    @(posedge clk_50MHz);
    #1;
  endtask

  initial begin
    @(posedge clk_50MHz);
    #1;
    do_reset();

    // Zero-wait stream: A000, A001, ... on consecutive cycles.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Ack every third cycle: two bubbles between valid words.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 16'h0, (i % 3) == 2);

    // Reset mid-fetch, then stall while pc=5 is acked.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Redirect under stall with a word parked: parked word is dropped.
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0040, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // PC wrap FFFF -> 0000, then a long stall to fill any prefetch storage.
    step(1'b0, 1'b1, 16'hFFFE, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1);

    // Random mix of stalls, wait states and redirects.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           16'($urandom), $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    check_eq("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
